// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, reset PC, NOP and major opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with sequential advance and redirect; redirect always wins.
// FETCH_MISALIGN_CHECK_EN: word-align redirect targets and flag misaligned ones (sticky).
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        misalign_err_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q, err_d;

    assign target_pc = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        err_d = err_q;
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign misalign_err_o = err_q;
`else
    assign target_pc      = redirect_pc_i;
    assign misalign_err_o = 1'b0;
`endif

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_pc;
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // NOTE: state registers use <= so all flops sample pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait, hold for decoder, drain on redirect.
// FETCH_MISALIGN_CHECK_EN enables misaligned-redirect detection inside fetch_pc_reg.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  pc;

    // Gated by rst so the request is low throughout reset and rises right after release.
    assign imem_req    = rst && (state_q == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state_q == S_FULL);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .advance_i     (imem_req && imem_gnt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .misalign_err_o(misalign_err)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    state_d = imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    state_d    = S_FULL;
                    instr_d    = imem_rdata;
                    // pc already advanced past the granted word and cannot have been redirected here.
                    instr_pc_d = pc - 32'd4;
                end
            end
            S_FULL: begin
                if (redirect || instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of words expected at the decoder.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample just after the driving edge, score any handshake, then advance to the next negedge.
    task automatic step();
        #1;
        if (instr_valid && instr_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_instr: observed instr_pc %h expected no instr_valid", instr_pc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.word);
            end
        end
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
        redirect_pc = '0;
    endtask

    // From S_REQ: grant, respond one cycle later, end in S_FULL.
    task automatic to_full(input logic [31:0] addr, input logic [31:0] data, input bit push);
        check("req_in_req", imem_req, 32'd1);
        check("imem_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("req_in_wait", imem_req, 32'd0);
        check("valid_in_wait", instr_valid, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (push) sb.push_back('{addr, data});
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("valid_in_full", instr_valid, 32'd1);
    endtask

    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input int stall);
        to_full(addr, data, 1'b1);
        instr_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", instr_valid, 32'd1);
            check("stall_instr", instr, data);
            check("stall_instr_pc", instr_pc, addr);
            check("stall_req", imem_req, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("valid_after_take", instr_valid, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misalign", misalign_err, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        #1;
        check("release_req", imem_req, 32'd1);
        check("release_addr", imem_addr, 32'd0);
        @(negedge clk);

        // Streaming with the decoder always ready: valid pulses once per 3 cycles.
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_full(32'(i * 4), 32'h0010_0093 + 32'(i << 20), 1'b1);
            step();
            check("pulse_end", instr_valid, 32'd0);
        end
        instr_ready = 1'b0;

        // Backpressure for 5 cycles.
        fetch_word(32'h0000_000C, 32'h0050_0093, 5);

        // Redirect while waiting; late response must be dropped.
        check("pre_redir_addr", imem_addr, 32'h0000_0010);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect_to(32'h0000_0100);
        check("drain_req", imem_req, 32'd0);
        check("drain_valid", instr_valid, 32'd0);
        step();
        check("drain_req2", imem_req, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0001;
        step();
        imem_rvalid = 1'b0;
        check("after_drain_req", imem_req, 32'd1);
        check("after_drain_valid", instr_valid, 32'd0);
        fetch_word(32'h0000_0100, 32'h00A0_0113, 0);

        // Redirect coincident with grant: drain, drop the response.
        check("pre_gnt_redir_addr", imem_addr, 32'h0000_0104);
        imem_gnt = 1'b1;
        redirect_to(32'h0000_0200);
        imem_gnt = 1'b0;
        check("gnt_redir_req", imem_req, 32'd0);
        check("gnt_redir_valid", instr_valid, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0002;
        step();
        imem_rvalid = 1'b0;
        check("gnt_redir_valid2", instr_valid, 32'd0);
        check("gnt_redir_addr", imem_addr, 32'h0000_0200);

        // Stray rvalid in S_REQ is ignored.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0003;
        step();
        imem_rvalid = 1'b0;
        check("stray_req", imem_req, 32'd1);
        check("stray_addr", imem_addr, 32'h0000_0200);
        check("stray_valid", instr_valid, 32'd0);

        // Redirect coincident with rvalid: response dropped, straight back to S_REQ.
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0004;
        redirect_to(32'h0000_0300);
        imem_rvalid = 1'b0;
        check("rv_redir_valid", instr_valid, 32'd0);
        check("rv_redir_req", imem_req, 32'd1);
        check("rv_redir_addr", imem_addr, 32'h0000_0300);

        // Redirect while holding a word for the decoder.
        to_full(32'h0000_0300, 32'hDEAD_0005, 1'b0);
        redirect_to(32'hFFFF_FFFC);
        check("full_redir_valid", instr_valid, 32'd0);
        check("full_redir_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space.
        fetch_word(32'hFFFF_FFFC, 32'h0000_0033, 0);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        fetch_word(32'h0000_0000, 32'h0000_0063, 1);

        // Misaligned redirect target.
        redirect_to(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_set", misalign_err, 32'd1);
        check("misalign_addr", imem_addr, 32'h0000_0100);
        fetch_word(32'h0000_0100, 32'h0000_0003, 0);
        check("misalign_sticky", misalign_err, 32'd1);
`else
        check("misalign_off", misalign_err, 32'd0);
        check("misalign_addr_raw", imem_addr, 32'h0000_0102);
        fetch_word(32'h0000_0102, 32'h0000_0003, 0);
`endif

        // Reset in the middle of a transaction.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0006;
        #1;
        check("rerelease_addr", imem_addr, 32'h0000_0000);
        step();
        imem_rvalid = 1'b0;
        check("rerelease_valid", instr_valid, 32'd0);
        fetch_word(32'h0000_0000, 32'h0000_0023, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
